// File: rtl/oq_sram_port_arbiter_pkg.sv
// rtl/oq_sram_port_arbiter_pkg.sv - shared widths, latency defaults and grant encoding
package oq_sram_port_arbiter_pkg;
    localparam int SRAM_WORD_WIDTH       = 72;
    localparam int RD_LATENCY_DEFAULT    = 2;
    localparam int WR_DATA_DELAY_DEFAULT = 2;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;
endpackage

// File: rtl/oq_sram_port_arbiter_if.sv
// rtl/oq_sram_port_arbiter_if.sv - requester ports and SRAM bus of the output-queue SRAM arbiter
interface oq_sram_port_arbiter_if
    import oq_sram_port_arbiter_pkg::*;
#(
    parameter int SAW        = 19,
    parameter int WORD_WIDTH = SRAM_WORD_WIDTH
);
    logic                  wr_0_req;
    logic [SAW-1:0]        wr_0_addr;
    logic [WORD_WIDTH-1:0] wr_0_data;
    logic                  wr_0_ack;
    logic                  rd_0_req;
    logic [SAW-1:0]        rd_0_addr;
    logic                  rd_0_ack;
    logic [WORD_WIDTH-1:0] rd_0_data;
    logic                  rd_0_vld;
    logic [SAW-1:0]        sram_addr;
    logic                  sram_we;
    logic                  sram_rd_en;
    logic [WORD_WIDTH-1:0] sram_wr_data;
    logic                  sram_data_oe;
    logic [WORD_WIDTH-1:0] sram_rd_data;

    modport master (
        output wr_0_req, wr_0_addr, wr_0_data, rd_0_req, rd_0_addr, sram_rd_data,
        input  wr_0_ack, rd_0_ack, rd_0_data, rd_0_vld,
        input  sram_addr, sram_we, sram_rd_en, sram_wr_data, sram_data_oe
    );

    modport slave (
        input  wr_0_req, wr_0_addr, wr_0_data, rd_0_req, rd_0_addr, sram_rd_data,
        output wr_0_ack, rd_0_ack, rd_0_data, rd_0_vld,
        output sram_addr, sram_we, sram_rd_en, sram_wr_data, sram_data_oe
    );
endinterface

// File: rtl/oq_sram_delay_line.sv
// rtl/oq_sram_delay_line.sv - DEPTH-stage shift register carrying a valid bit and a data word
module oq_sram_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] data [DEPTH];

    // Data is zeroed when no token enters so the output is 0 whenever out_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else begin
            vld[0]  <= in_valid;
            data[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]  <= vld[i-1];
                data[i] <= data[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = data[DEPTH-1];
endmodule

// File: rtl/oq_sram_port_arbiter.sv
// rtl/oq_sram_port_arbiter.sv - round-robin write/read port arbiter onto one pipelined SRAM
module oq_sram_port_arbiter
    import oq_sram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int RD_LATENCY      = RD_LATENCY_DEFAULT,
    parameter int WR_DATA_DELAY   = WR_DATA_DELAY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    oq_sram_port_arbiter_if.slave bus
);
    localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;

    grant_t                       last_grant;
    grant_t                       last_grant_nxt;
    logic                         grant_wr;
    logic                         grant_rd;
    logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_q;
    logic                         sram_we_q;
    logic                         sram_rd_en_q;
    logic                         wr_pipe_vld;
    logic [WORD_WIDTH-1:0]        wr_pipe_data;
    logic                         rd_pipe_vld;
    logic [0:0]                   rd_pipe_data;
    logic                         rd_tok;
    logic                         rd_0_vld_q;
    logic [WORD_WIDTH-1:0]        rd_0_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_RD;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Ties go to the port that did not win last; a lone requester always wins.
    always_comb begin
        grant_wr       = 1'b0;
        grant_rd       = 1'b0;
        last_grant_nxt = last_grant;
        if (!reset) begin
            if (bus.wr_0_req && (!bus.rd_0_req || last_grant == GRANT_RD)) begin
                grant_wr       = 1'b1;
                last_grant_nxt = GRANT_WR;
            end else if (bus.rd_0_req) begin
                grant_rd       = 1'b1;
                last_grant_nxt = GRANT_RD;
            end
        end
    end

    assign bus.wr_0_ack = grant_wr;
    assign bus.rd_0_ack = grant_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_addr_q  <= '0;
            sram_we_q    <= 1'b0;
            sram_rd_en_q <= 1'b0;
        end else begin
            sram_we_q    <= grant_wr;
            sram_rd_en_q <= grant_rd;
            if (grant_wr) begin
                sram_addr_q <= bus.wr_0_addr;
            end else if (grant_rd) begin
                sram_addr_q <= bus.rd_0_addr;
            end
        end
    end

    // One extra stage accounts for the command register in front of the SRAM.
    oq_sram_delay_line #(
        .DEPTH (WR_DATA_DELAY + 1),
        .WIDTH (WORD_WIDTH)
    ) u_wr_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (grant_wr),
        .in_data   (bus.wr_0_data),
        .out_valid (wr_pipe_vld),
        .out_data  (wr_pipe_data)
    );

    oq_sram_delay_line #(
        .DEPTH (RD_LATENCY + 1),
        .WIDTH (1)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (grant_rd),
        .in_data   (1'b1),
        .out_valid (rd_pipe_vld),
        .out_data  (rd_pipe_data)
    );

    assign rd_tok = rd_pipe_vld & rd_pipe_data[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_0_vld_q  <= 1'b0;
            rd_0_data_q <= '0;
        end else begin
            rd_0_vld_q <= rd_tok;
            if (rd_tok) begin
                rd_0_data_q <= bus.sram_rd_data;
            end
        end
    end

    assign bus.sram_addr    = sram_addr_q;
    assign bus.sram_we      = sram_we_q;
    assign bus.sram_rd_en   = sram_rd_en_q;
    assign bus.sram_wr_data = wr_pipe_data;
    assign bus.sram_data_oe = wr_pipe_vld;
    assign bus.rd_0_vld     = rd_0_vld_q;
    assign bus.rd_0_data    = rd_0_data_q;
endmodule

// File: tb/tb_oq_sram_port_arbiter.sv
// tb/tb_oq_sram_port_arbiter.sv - directed self-checking bench for oq_sram_port_arbiter
module tb_oq_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    oq_sram_port_arbiter_if #(.SAW(19), .WORD_WIDTH(72)) bus ();

    oq_sram_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pipelined SRAM model: address registered twice; write data lands with sram_data_oe.
    logic [71:0] mem [512];
    bit          wr_seen [512];
    bit   [8:0]  rd_a1, rd_a2, wa1, wa2;

    function automatic logic [71:0] pat(input logic [8:0] a);
        return {8'hA5, 32'hDEAD_BEEF, 23'h0, a};
    endfunction

    function automatic logic [71:0] dw(input int k);
        return {64'h3C3C_0000_0000_0000, 8'(k)};
    endfunction

    always @(posedge clk) begin
        rd_a1 <= bus.sram_addr[8:0];
        rd_a2 <= rd_a1;
        wa1   <= bus.sram_addr[8:0];
        wa2   <= wa1;
        if (bus.sram_data_oe) begin
            mem[wa2]     <= bus.sram_wr_data;
            wr_seen[wa2] <= 1'b1;
        end
    end

    assign bus.sram_rd_data = wr_seen[rd_a2] ? mem[rd_a2] : pat(rd_a2);

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wr_ack"}, 72'(bus.wr_0_ack), 72'd0);
        chk({tag, ".rd_ack"}, 72'(bus.rd_0_ack), 72'd0);
        chk({tag, ".vld"}, 72'(bus.rd_0_vld), 72'd0);
        chk({tag, ".rd_data"}, bus.rd_0_data, 72'd0);
        chk({tag, ".addr"}, 72'(bus.sram_addr), 72'd0);
        chk({tag, ".we"}, 72'(bus.sram_we), 72'd0);
        chk({tag, ".rd_en"}, 72'(bus.sram_rd_en), 72'd0);
        chk({tag, ".wr_data"}, bus.sram_wr_data, 72'd0);
        chk({tag, ".oe"}, 72'(bus.sram_data_oe), 72'd0);
    endtask

    task automatic cyc(input logic wq, input logic [18:0] wa, input logic [71:0] wd,
                       input logic rq, input logic [18:0] ra);
        @(negedge clk);
        bus.wr_0_req  = wq;
        bus.wr_0_addr = wa;
        bus.wr_0_data = wd;
        bus.rd_0_req  = rq;
        bus.rd_0_addr = ra;
        #1;
    endtask

    localparam logic [71:0] D1 = 72'h0A_AAAA_AAAA_AAAA_AAAA;
    localparam logic [71:0] D4 = 72'h77_1234_5678_9ABC_DEF0;

    initial begin
        bus.wr_0_req  = 1'b0;
        bus.wr_0_addr = '0;
        bus.wr_0_data = '0;
        bus.rd_0_req  = 1'b0;
        bus.rd_0_addr = '0;

        @(negedge clk);
        #1;
        chk_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // 1: single write
        cyc(1'b1, 19'h00010, D1, 1'b0, 19'h0);
        chk("t1.c0.wr_ack", 72'(bus.wr_0_ack), 72'd1);
        chk("t1.c0.rd_ack", 72'(bus.rd_0_ack), 72'd0);
        cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
        chk("t1.c1.we", 72'(bus.sram_we), 72'd1);
        chk("t1.c1.addr", 72'(bus.sram_addr), 72'h10);
        chk("t1.c1.oe", 72'(bus.sram_data_oe), 72'd0);
        cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
        chk("t1.c2.we", 72'(bus.sram_we), 72'd0);
        chk("t1.c2.addr_hold", 72'(bus.sram_addr), 72'h10);
        chk("t1.c2.oe", 72'(bus.sram_data_oe), 72'd0);
        cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
        chk("t1.c3.oe", 72'(bus.sram_data_oe), 72'd1);
        chk("t1.c3.wr_data", bus.sram_wr_data, D1);
        cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
        chk("t1.c4.oe", 72'(bus.sram_data_oe), 72'd0);

        // 2: single read of the word just written
        cyc(1'b0, 19'h0, 72'h0, 1'b1, 19'h00010);
        chk("t2.c0.rd_ack", 72'(bus.rd_0_ack), 72'd1);
        chk("t2.c0.wr_ack", 72'(bus.wr_0_ack), 72'd0);
        for (int j = 1; j <= 5; j++) begin
            cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
            if (j == 1) begin
                chk("t2.c1.rd_en", 72'(bus.sram_rd_en), 72'd1);
                chk("t2.c1.addr", 72'(bus.sram_addr), 72'h10);
            end
            chk($sformatf("t2.c%0d.vld", j), 72'(bus.rd_0_vld), 72'(j == 4));
            if (j == 4) chk("t2.c4.rd_data", bus.rd_0_data, D1);
        end

        // 3: both ports requesting from reset
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero("t3.rst");
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 14; j++) begin
            cyc(j < 8, 19'(32'h20 + (j + 1) / 2), dw((j + 1) / 2), j < 8, 19'(32'h20 + j / 2));
            if (j < 8) begin
                chk($sformatf("t3.c%0d.wr_ack", j), 72'(bus.wr_0_ack), 72'(j % 2 == 0));
                chk($sformatf("t3.c%0d.rd_ack", j), 72'(bus.rd_0_ack), 72'(j % 2 == 1));
            end
            chk($sformatf("t3.c%0d.oe", j), 72'(bus.sram_data_oe),
                72'(j == 3 || j == 5 || j == 7 || j == 9));
            if (j == 3 || j == 5 || j == 7 || j == 9)
                chk($sformatf("t3.c%0d.wr_data", j), bus.sram_wr_data, dw((j - 3) / 2));
            chk($sformatf("t3.c%0d.vld", j), 72'(bus.rd_0_vld),
                72'(j == 5 || j == 7 || j == 9 || j == 11));
            if (j == 5 || j == 7 || j == 9 || j == 11)
                chk($sformatf("t3.c%0d.rd_data", j), bus.rd_0_data, dw((j - 5) / 2));
        end

        // 4: read-after-write to the same address returns the new word
        cyc(1'b1, 19'h00123, D4, 1'b0, 19'h0);
        chk("t4.wr_ack", 72'(bus.wr_0_ack), 72'd1);
        cyc(1'b0, 19'h0, 72'h0, 1'b1, 19'h00123);
        chk("t4.rd_ack", 72'(bus.rd_0_ack), 72'd1);
        for (int j = 2; j <= 6; j++) begin
            cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
            chk($sformatf("t4.c%0d.vld", j), 72'(bus.rd_0_vld), 72'(j == 5));
            if (j == 5) chk("t4.rd_data", bus.rd_0_data, D4);
        end

        // 5: 16-read burst
        for (int j = 0; j < 22; j++) begin
            cyc(1'b0, 19'h0, 72'h0, j < 16, 19'(32'h40 + j));
            chk($sformatf("t5.c%0d.rd_ack", j), 72'(bus.rd_0_ack), 72'(j < 16));
            chk($sformatf("t5.c%0d.vld", j), 72'(bus.rd_0_vld), 72'(j >= 4 && j < 20));
            if (j >= 4 && j < 20)
                chk($sformatf("t5.c%0d.rd_data", j), bus.rd_0_data, pat(9'(32'h40 + j - 4)));
        end

        // 6: reset with reads and a write in flight
        cyc(1'b0, 19'h0, 72'h0, 1'b1, 19'h00061);
        chk("t6.c0.rd_ack", 72'(bus.rd_0_ack), 72'd1);
        cyc(1'b0, 19'h0, 72'h0, 1'b1, 19'h00062);
        chk("t6.c1.rd_ack", 72'(bus.rd_0_ack), 72'd1);
        cyc(1'b1, 19'h00060, 72'h55, 1'b0, 19'h0);
        chk("t6.c2.wr_ack", 72'(bus.wr_0_ack), 72'd1);
        cyc(1'b0, 19'h0, 72'h0, 1'b1, 19'h00063);
        chk("t6.c3.rd_ack", 72'(bus.rd_0_ack), 72'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.wr_0_req = 1'b1;
        bus.rd_0_req = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #1;
            chk_zero($sformatf("t6.rst%0d", j));
        end
        @(negedge clk);
        reset = 1'b0;
        bus.wr_0_req = 1'b0;
        bus.rd_0_req = 1'b0;
        #1;
        chk_zero("t6.rel0");
        for (int j = 1; j < 8; j++) begin
            cyc(1'b0, 19'h0, 72'h0, 1'b0, 19'h0);
            chk_zero($sformatf("t6.rel%0d", j));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
